// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: FSM state encodings, error pattern, mailbox default address and byte-lane merge helper.
package dmem_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
  localparam logic [31:0] DEFAULT_DONE_ADDR = 32'h300;
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] wen);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = wen[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return m;
  endfunction
endpackage

// File: rtl/dmem_sram_bank.sv
// dmem_sram_bank: MEM_WORDS x 32 RAM with per-byte write enables and a combinational read port.
module dmem_sram_bank #(
  parameter int MEM_WORDS = 1024,
  parameter int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [MEM_WORDS];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && wen[i]) mem[addr][8*i+:8] <= wdata[8*i+:8];
  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable response latency.
// Define DMEM_MAILBOX_EN to enable the sticky test-done mailbox at DONE_ADDR.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] DONE_ADDR = DEFAULT_DONE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        done_flag,
  output logic [31:0] done_code
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  if (LATENCY > 15 || LATENCY < 0) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 0..15");
  end
  if (DONE_ADDR[1:0] != 2'b00) begin : g_bad_done_addr
    $error("dmem_responder: DONE_ADDR must be word aligned");
  end
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] ram_rdata;
  logic        accept, addr_err, wr_en;
  assign accept   = (state_q == IDLE) && req_valid;
  assign addr_err = (req_addr >= 32'(4 * MEM_WORDS)) || (req_addr[1:0] != 2'b00);
  // RAM is only touched by an in-range request on the accept edge, never while held in reset.
  assign wr_en    = rst_n && accept && !addr_err && (|req_wen);
  dmem_sram_bank #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_bank (
    .clk  (clk),
    .we   (wr_en),
    .wen  (req_wen),
    .addr (req_addr[AW+1:2]),
    .wdata(req_wdata),
    .rdata(ram_rdata)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_valid) begin
          rsp_err_q   <= addr_err;
          rsp_rdata_q <= addr_err ? ERR_DATA : merge_lanes(ram_rdata, req_wdata, req_wen);
          cnt_q       <= CNT_INIT;
          state_q     <= (LATENCY == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_q <= RESP;
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef DMEM_MAILBOX_EN
  logic        done_flag_q;
  logic [31:0] done_code_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_flag_q <= 1'b0;
      done_code_q <= 32'd0;
    end else if (wr_en && req_wen == 4'hF && req_addr == DONE_ADDR && (|req_wdata) && !done_flag_q) begin
      done_flag_q <= 1'b1;
      done_code_q <= req_wdata;
    end
  end
  assign done_flag = done_flag_q;
  assign done_code = done_code_q;
`else
  assign done_flag = 1'b0;
  assign done_code = 32'd0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven vectors plus directed sequences for backpressure, mailbox and reset abort.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, done_flag;
  logic [31:0] req_addr, req_wdata, rsp_rdata, done_code;
  logic [3:0]  req_wen;
  int total = 0, passed = 0;
`ifdef DMEM_MAILBOX_EN
  localparam bit MB = 1'b1;
`else
  localparam bit MB = 1'b0;
`endif
  always #5 clk = ~clk;
  dmem_responder #(.MEM_WORDS(1024), .LATENCY(2), .DONE_ADDR(32'h300)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_wen  (req_wen),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .done_flag(done_flag),
    .done_code(done_code)
  );
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vt [17];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic xact(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_addr = a; req_wen = w; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    vt[0]  = '{32'h200, 4'hF, 32'h0000002A, 32'h0000002A, 1'b0};
    vt[1]  = '{32'h200, 4'h0, 32'h0,        32'h0000002A, 1'b0};
    vt[2]  = '{32'h204, 4'hF, 32'h11223344, 32'h11223344, 1'b0};
    vt[3]  = '{32'h204, 4'h2, 32'h0000AB00, 32'h1122AB44, 1'b0};
    vt[4]  = '{32'h204, 4'h0, 32'h0,        32'h1122AB44, 1'b0};
    vt[5]  = '{32'h000, 4'hF, 32'h12345678, 32'h12345678, 1'b0};
    vt[6]  = '{32'h1000, 4'h0, 32'h0,       32'hDEADBEEF, 1'b1};
    vt[7]  = '{32'h1000, 4'hF, 32'h55,      32'hDEADBEEF, 1'b1};
    vt[8]  = '{32'h000, 4'h0, 32'h0,        32'h12345678, 1'b0};
    vt[9]  = '{32'h202, 4'hF, 32'h99,       32'hDEADBEEF, 1'b1};
    vt[10] = '{32'h200, 4'h0, 32'h0,        32'h0000002A, 1'b0};
    vt[11] = '{32'hFFC, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vt[12] = '{32'hFFC, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0};
    vt[13] = '{32'h208, 4'hF, 32'h0,        32'h00000000, 1'b0};
    vt[14] = '{32'h208, 4'h9, 32'hAABBCCDD, 32'hAA0000DD, 1'b0};
    vt[15] = '{32'hFFF, 4'h0, 32'h0,        32'hDEADBEEF, 1'b1};
    vt[16] = '{32'h208, 4'h0, 32'h0,        32'hAA0000DD, 1'b0};
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wen = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset done_flag", 32'(done_flag), 32'd0);
    chk("reset done_code", done_code, 32'd0);
    for (int i = 0; i < 17; i++) begin
      xact(vt[i].addr, vt[i].wen, vt[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
    end
    // backpressure: response held, competing write ignored
    @(negedge clk);
    req_addr = 32'h204; req_wen = 4'h0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", 32'(lat), 32'd3);
    @(negedge clk);
    req_addr = 32'h204; req_wen = 4'hF; req_wdata = 32'h0; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d rsp_rdata", c), rsp_rdata, 32'h1122AB44);
      chk($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0; req_valid = 1'b0;
    chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp release req_ready", 32'(req_ready), 32'd1);
    xact(32'h204, 4'h0, 32'h0, rd, er, lat);
    chk("bp ignored write", rd, 32'h1122AB44);
    // mailbox
    xact(32'h300, 4'hF, 32'h0, rd, er, lat);
    chk("mbox zero flag", 32'(done_flag), 32'd0);
    xact(32'h300, 4'h1, 32'h5, rd, er, lat);
    chk("mbox partial rdata", rd, 32'h5);
    chk("mbox partial flag", 32'(done_flag), 32'd0);
    xact(32'h300, 4'hF, 32'h1, rd, er, lat);
    chk("mbox first flag", 32'(done_flag), 32'(MB));
    chk("mbox first code", done_code, MB ? 32'h1 : 32'h0);
    xact(32'h300, 4'hF, 32'h7, rd, er, lat);
    chk("mbox second flag", 32'(done_flag), 32'(MB));
    chk("mbox second code", done_code, MB ? 32'h1 : 32'h0);
    xact(32'h300, 4'h0, 32'h0, rd, er, lat);
    chk("mbox readback", rd, 32'h7);
    // reset during WAIT
    @(negedge clk);
    req_addr = 32'h214; req_wen = 4'hF; req_wdata = 32'hFFFFFFF9; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    chk("abort in wait", 32'(req_ready), 32'd0);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort done_flag", 32'(done_flag), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("abort no late rsp", 32'(rsp_valid), 32'd0);
    xact(32'h214, 4'h0, 32'h0, rd, er, lat);
    chk("abort write kept", rd, 32'hFFFFFFF9);
    chk("abort readback err", 32'(er), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
